// File: rtl/ask_burst_mod.sv
// ask_burst_mod: burst-shaped ASK modulator.
// The carrier level is added to the baseband, the sum is mixed with the LO,
// and a linear ramp envelope is applied. The envelope is driven by an
// enable-controlled IDLE/UP/ON/DOWN state machine. The data path is a fixed
// 3-stage pipeline with no stalls. The envelope is delayed by two clocks so
// that each sample meets the gain that was current when it entered.
module ask_burst_mod #(
  parameter int RAMP_LEN = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [15:0] bb,
  input  logic signed [15:0] lo,
  input  logic signed [15:0] offset,
  input  logic               clr_sat,
  output logic signed [15:0] dout,
  output logic        [15:0] env,
  output logic               busy,
  output logic               sat
);

  // Gain arithmetic uses 17 bits so that unity (32768) and the ramp step are representable.
  localparam logic [16:0] FULL   = 17'd32768;
  localparam logic [16:0] STEP   = 17'(32768 / RAMP_LEN);
  localparam logic [16:0] FULL_M = FULL - STEP;
  localparam logic [15:0] STEP16 = STEP[15:0];
  localparam logic [15:0] FULL16 = FULL[15:0];
  localparam logic [15:0] FM16   = FULL_M[15:0];

  localparam logic signed [15:0] POS_MAX = 16'sh7fff;
  localparam logic signed [15:0] NEG_MAX = 16'sh8000;

  typedef enum logic [1:0] {IDLE, UP, ON, DOWN} state_e;

  state_e state_q, state_d;

  logic [15:0] env_q, env_d;
  logic [15:0] env_d1_q, env_d2_q;

  logic signed [15:0] s1_q, s1_d;
  logic signed [15:0] lo_q;
  logic signed [15:0] s2_q, s2_d;
  logic signed [15:0] dout_q, dout_d;
  logic               sat_q, sat_d;

  // ------------------------------------------------------------------
  // Stage 1: the carrier level is added to the baseband, then the sum saturates to 16 bits.
  // ------------------------------------------------------------------
  logic [16:0] sum1;
  logic        clamp1;

  assign sum1   = {bb[15], bb} + {offset[15], offset};
  // The 17-bit sum does not fit in 16 bits when its two top bits differ.
  assign clamp1 = sum1[16] ^ sum1[15];

  // Stage 1 clamp selection.
  always_comb begin
    s1_d = sum1[15:0];
    if (clamp1) s1_d = sum1[16] ? NEG_MAX : POS_MAX;
  end

  // ------------------------------------------------------------------
  // Stage 2: mix with the LO, using a Q15 product with a floor shift.
  // ------------------------------------------------------------------
  logic signed [31:0] a2, b2, prod2;
  logic               clamp2;

  assign a2     = {{16{s1_q[15]}}, s1_q};
  assign b2     = {{16{lo_q[15]}}, lo_q};
  assign prod2  = a2 * b2;
  // prod2[31:15] is the floor-shifted value. Only -32768 * -32768 reaches +32768.
  assign clamp2 = prod2[31] ^ prod2[30];

  // Stage 2 clamp selection.
  always_comb begin
    s2_d = prod2[30:15];
    if (clamp2) s2_d = prod2[31] ? NEG_MAX : POS_MAX;
  end

  // ------------------------------------------------------------------
  // Stage 3: apply the envelope. |s2 * env| <= 2^30, so the result fits 16 bits.
  // ------------------------------------------------------------------
  logic signed [32:0] a3, b3, prod3;

  assign a3     = {{17{s2_q[15]}}, s2_q};
  assign b3     = {17'd0, env_d2_q};
  assign prod3  = a3 * b3;
  assign dout_d = prod3[30:15];

  // Bits discarded by the Q15 shifts.
  logic unused_bits;
  assign unused_bits = ^{prod2[14:0], prod3[32:31], prod3[14:0]};

  // Sticky saturation flag. A clamp on the same edge as a clear wins.
  assign sat_d = clamp1 | clamp2 | (sat_q & ~clr_sat);

  // ------------------------------------------------------------------
  // Envelope state machine: ramps env linearly by STEP toward unity or zero.
  // ------------------------------------------------------------------
  logic [16:0] env17, up_v, dn_v;

  assign env17 = {1'b0, env_q};
  assign up_v  = env17 + STEP;
  assign dn_v  = env17 - STEP;

  // Next state and next envelope level. A reversal continues from the current level.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    unique case (state_q)
      IDLE: begin
        env_d = 16'd0;
        if (en) begin
          env_d   = STEP16;
          state_d = (STEP == FULL) ? ON : UP;
        end
      end
      UP: begin
        if (en) begin
          env_d   = up_v[15:0];
          state_d = (up_v == FULL) ? ON : UP;
        end else begin
          env_d   = dn_v[15:0];
          state_d = (dn_v == 17'd0) ? IDLE : DOWN;
        end
      end
      ON: begin
        env_d = FULL16;
        if (!en) begin
          env_d   = FM16;
          state_d = (FULL_M == 17'd0) ? IDLE : DOWN;
        end
      end
      DOWN: begin
        if (!en) begin
          env_d   = dn_v[15:0];
          state_d = (dn_v == 17'd0) ? IDLE : DOWN;
        end else begin
          env_d   = up_v[15:0];
          state_d = (up_v == FULL) ? ON : UP;
        end
      end
      default: begin
        state_d = IDLE;
        env_d   = 16'd0;
      end
    endcase
  end

  // Registers for the state machine and the envelope delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      env_q    <= 16'd0;
      env_d1_q <= 16'd0;
      env_d2_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      env_d1_q <= env_q;
      env_d2_q <= env_d1_q;
    end
  end

  // Data pipeline registers and the sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '0;
      lo_q   <= '0;
      s2_q   <= '0;
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      lo_q   <= lo;
      s2_q   <= s2_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign dout = dout_q;
  assign env  = env_q;
  assign busy = (state_q != IDLE);
  assign sat  = sat_q;

endmodule

// File: tb/tb_ask_burst_mod.sv
// Bench for ask_burst_mod. Two instances run side by side, one with RAMP_LEN = 256
// and one with RAMP_LEN = 1, against an arithmetic reference model.
module tb_ask_burst_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               en0, en1, clr;
  logic signed [15:0] bb, lo, off;
  logic signed [15:0] dout0, dout1;
  logic        [15:0] env0, env1;
  logic               busy0, busy1, sat0, sat1;

  ask_burst_mod #(.RAMP_LEN(256)) u0 (
    .clk(clk), .rst(rst), .en(en0), .bb(bb), .lo(lo), .offset(off),
    .clr_sat(clr), .dout(dout0), .env(env0), .busy(busy0), .sat(sat0)
  );

  ask_burst_mod #(.RAMP_LEN(1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .bb(bb), .lo(lo), .offset(off),
    .clr_sat(clr), .dout(dout1), .env(env1), .busy(busy1), .sat(sat1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int k;

  // Reference model state: gain level, 3-deep output history, and flag.
  int m_step [2] = '{128, 32768};
  int m_env  [2];
  int m_p    [2][3];
  int m_sat  [2];
  int m_c2p  [2];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int y_of(input int b, input int l, input int o, input int e);
    int s1, s2;
    longint p;
    s1 = sat16(b + o);
    s2 = sat16((s1 * l) >>> 15);
    p  = longint'(s2) * longint'(e);
    return int'(p >>> 15);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_env[i] = 0; m_sat[i] = 0; m_c2p[i] = 0;
      for (int j = 0; j < 3; j++) m_p[i][j] = 0;
    end
  endtask

  task automatic check_all();
    chk("env0",  env0,  m_env[0]);
    chk("busy0", busy0, (m_env[0] != 0) ? 1 : 0);
    chk("dout0", dout0, m_p[0][2]);
    chk("sat0",  sat0,  m_sat[0]);
    chk("env1",  env1,  m_env[1]);
    chk("busy1", busy1, (m_env[1] != 0) ? 1 : 0);
    chk("dout1", dout1, m_p[1][2]);
    chk("sat1",  sat1,  m_sat[1]);
  endtask

  // One clock: advance the model from the inputs present at the edge, then check 1 ns later.
  task automatic tick();
    int b, l, o, e, s1, c1, c2, enx;
    @(posedge clk);
    b = bb; l = lo; o = off;
    if (!rst) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin
        e   = m_env[i];
        enx = (i == 0) ? en0 : en1;
        c1  = ((b + o) > 32767 || (b + o) < -32768) ? 1 : 0;
        s1  = sat16(b + o);
        c2  = (((s1 * l) >>> 15) > 32767) ? 1 : 0;
        m_sat[i] = (c1 != 0 || m_c2p[i] != 0 || (m_sat[i] != 0 && !clr)) ? 1 : 0;
        m_c2p[i] = c2;
        m_p[i][2] = m_p[i][1];
        m_p[i][1] = m_p[i][0];
        m_p[i][0] = y_of(b, l, o, e);
        if (enx) m_env[i] = (e + m_step[i] > 32768) ? 32768 : e + m_step[i];
        else     m_env[i] = (e - m_step[i] < 0) ? 0 : e - m_step[i];
      end
    end
    #1;
    check_all();
    k++;
  endtask

  initial begin
    rst = 1'b0; en0 = 0; en1 = 0; clr = 0; bb = 0; lo = 0; off = 0;
    model_reset();
    #3;
    check_all();
    repeat (2) tick();
    #2 rst = 1'b1;

    // Steady ON ramp with a known carrier.
    bb = 0; off = 10000; lo = 32767; en0 = 1; k = 0;
    repeat (262) begin
      tick();
      if (k == 1)   chk("up_first", env0, 128);
      if (k == 131) chk("half_dout", dout0, 4999);
      if (k == 256) chk("full_env", env0, 32768);
      if (k == 262) chk("steady_dout", dout0, 9999);
    end

    // Ramp down to IDLE.
    en0 = 0; k = 0;
    repeat (259) begin
      tick();
      if (k == 1)   chk("down_first", env0, 32640);
      if (k == 2)   chk("down_second", env0, 32512);
      if (k == 255) chk("down_last_busy", busy0, 1);
      if (k == 256) chk("down_zero_env", env0, 0);
      if (k == 256) chk("down_zero_busy", busy0, 0);
      if (k == 259) chk("down_dout_zero", dout0, 0);
    end

    // Reversal in the middle of a ramp.
    en0 = 1;
    repeat (100) tick();
    chk("rev_at", env0, 12800);
    en0 = 0; tick(); chk("rev_down", env0, 12672);
    tick();          chk("rev_low", env0, 12544);
    en0 = 1; tick(); chk("rev_up", env0, 12672);
    chk("rev_busy", busy0, 1);
    repeat (29) tick();
    chk("pre_reset_env", env0, 16384);

    // Asynchronous reset in the middle of a ramp, checked without a clock edge.
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_env", env0, 0);
    en0 = 0;
    repeat (3) tick();
    #2 rst = 1'b1;
    repeat (5) tick();
    chk("rst_idle_busy", busy0, 0);

    // Saturation cases.
    bb = 30000; off = 10000; lo = 32767; en0 = 1;
    repeat (260) tick();
    chk("sat_dout", dout0, 32766);
    chk("sat_flag", sat0, 1);
    bb = 0; off = 100; lo = 1000; clr = 1;
    tick();
    chk("sat_clear", sat0, 0);
    clr = 0;
    bb = -32768; off = 0; lo = -32768;
    repeat (3) tick();
    chk("sat_neg_dout", dout0, 32767);
    chk("sat_neg_flag", sat0, 1);
    clr = 1;
    tick();
    chk("sat_set_wins", sat0, 1);
    bb = 0; off = 100; lo = 1000;
    repeat (2) tick();
    chk("sat_cleared", sat0, 0);
    clr = 0;

    // Single-edge ramps on the RAMP_LEN = 1 instance.
    bb = 0; off = 10000; lo = 32767;
    en1 = 1; tick(); chk("r1_on", env1, 32768);
    repeat (3) tick();
    chk("r1_dout", dout1, 9999);
    en1 = 0; tick(); chk("r1_off", env1, 0);
    chk("r1_busy", busy1, 0);
    for (int i = 0; i < 12; i++) begin
      en1 = i[0];
      tick();
    end

    // Random traffic. en0 changes rarely so that partial ramps and reversals occur.
    for (int i = 0; i < 700; i++) begin
      bb  = 16'($urandom);
      lo  = 16'($urandom);
      off = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000));
      if ($urandom_range(0, 39) == 0) en0 = ~en0;
      en1 = 1'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      if (i == 350) begin
        #2 rst = 1'b0;
        #1 model_reset();
        check_all();
        #2 rst = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ask_burst_mod.md
# ask_burst_mod

Burst-shaped ASK modulator stage that sits directly downstream of the baseband interpolator and the quadrature NCO. It adds a carrier-level offset to the interpolated baseband and multiplies the result by the LO. A linear envelope is then applied under an enable-driven ramp state machine, so bursts start and stop without spectral splatter. The block drives a DAC channel as a saturated signed 16-bit sample.

## Interface
- `RAMP_LEN`, default 256: ramp duration in clocks; a power of two in the range 1..32768; `STEP = 32768/RAMP_LEN`.
- `clk`  in  1: sample clock; every register updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-low (0 = reset).
- `en`  in  1: burst enable, level-sensitive, sampled each clock.
- `bb`  in  signed 16: interpolated baseband sample.
- `lo`  in  signed 16: LO cosine sample.
- `offset`  in  signed 16: carrier level added to `bb`.
- `clr_sat`  in  1: clears the sticky saturation flag.
- `dout`  out  signed 16: modulated, enveloped output.
- `env`  out  unsigned 16: current envelope gain, range 0..32768, where 32768 = unity.
- `busy`  out  1: high whenever state ≠ IDLE.
- `sat`  out  1: sticky saturation flag.

## Operation
- **Stage 1:** `s1 = sat16(bb + offset)`, computed at 17 bits and clamped to [-32768, 32767].
- **Stage 2:** `s2 = sat16((s1 * lo) >>> 15)`, using a 32-bit signed product and an arithmetic shift (floor). Only -32768 × -32768 overflows; it clamps to 32767.
- **Stage 3:** `dout = (s2 * env_d2) >>> 15`.
  - The product is 33-bit signed; `env_d2` is `env` delayed by 2 clocks.
  - The result always fits in 16 bits, so no clamp is applied.
- **Envelope state machine:** states IDLE, UP, ON, DOWN. `env` is a register.
  - IDLE: `env` = 0. If `en` = 1, go to UP and set `env` = `STEP`.
  - UP with `en` = 1: `env += STEP`. When the new value is 32768, go to ON in the same edge.
  - UP with `en` = 0: go to DOWN and set `env -= STEP`. The reversal starts from the current level, with no jump.
  - ON: `env` = 32768. If `en` = 0, go to DOWN and set `env` = 32768 − `STEP`.
  - DOWN with `en` = 0: `env -= STEP`. When the new value is 0, go to IDLE in the same edge.
  - DOWN with `en` = 1: go to UP and set `env += STEP`.
  - `RAMP_LEN` = 1: IDLE→ON and ON→IDLE each take a single edge, with `env` at 32768 or 0.
  - `env` is always a multiple of `STEP`; it never exceeds 32768 and never goes below 0.
- **`sat` flag:**
  - Set on any edge where the stage 1 or stage 2 clamp is active.
  - Cleared by `clr_sat` = 1.
  - If a set and a clear occur on the same edge, set wins.
- **`busy`:** combinational decode of the state register.

## Timing
- Reset values: every pipeline register is 0, state = IDLE, `env` = 0, `env_d1` = `env_d2` = 0, `dout` = 0, `sat` = 0, `busy` = 0.
  - Reset takes effect immediately; there is no dependency on `clk`.
- Assertion mid-burst forces `dout` = 0 and `env` = 0 at once.
- After release, the state machine restarts from IDLE at the first edge with `rst` = 1.
- Pipeline latency is 3 clocks: `dout[n+3] = f(bb[n], lo[n], offset[n], env[n])`, where `env[n]` is the value of `env` during cycle n. The data pipeline has no stall and no bubble.
- `en` rising before edge k: `env` = `STEP` after edge k and `busy` = 1 after edge k. `env` = 32768 after edge k + `RAMP_LEN` − 1.
- `en` falling while ON, before edge k: `env` = 0 and `busy` = 0 after edge k + `RAMP_LEN` − 1.
- Once `busy` = 0, `dout` becomes exactly 0 three clocks after `env` reached 0.

## Test plan
- **Reset:** assert `rst` = 0 mid-ramp with `env` = 16384 → `dout`, `env`, `busy` and `sat` are 0 with no clock edge. After release with `en` = 0, they stay 0.
- **Steady ON:** `RAMP_LEN` = 256, `bb` = 0, `offset` = 10000, `lo` = 32767, `en` held high.
  - Expect `env` = 128 after the first edge and 32768 after 256 edges.
  - Expect steady `dout` = 9999.
  - At `env` = 16384, the aligned `dout` is 4999.
- **Ramp down:** same stimulus, drop `en` in ON → `env` falls 32640, 32512, … to 0 over 256 edges. `busy` falls with the edge that yields 0, and `dout` = 0 three clocks later.
- **Reversal:** drop `en` at `env` = 12800 in UP → next value 12672. Raise `en` again at 12544 → next value 12672 and state UP. No discontinuity greater than `STEP`.
- **Saturation:**
  - `bb` = 30000, `offset` = 10000, `lo` = 32767, `env` = 32768 → `dout` = 32766 and `sat` = 1.
  - `bb` = -32768, `offset` = 0, `lo` = -32768 → `dout` = 32767 and `sat` = 1.
  - `clr_sat` pulsed with no active clamp → `sat` = 0 the next cycle.
  - `clr_sat` on the same edge as a clamp → `sat` stays 1.
- **`RAMP_LEN` = 1:** toggling `en` → `env` alternates between 0 and 32768 in one edge. `busy` tracks state, and `dout` follows with 3-clock latency.
